// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the FSM state enum, matrix dimensions and the priority row picker.
package keypad_scan_pkg;

  localparam int NUM_COLS   = 4;
  localparam int NUM_ROWS   = 4;
  localparam int KEY_CODE_W = 4;
  localparam int IDX_W      = $clog2(NUM_COLS);
  localparam int ROW_W      = $clog2(NUM_ROWS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_t;

  // Lowest-index row that reads low; only meaningful when at least one row is low.
  function automatic logic [ROW_W-1:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows_n);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows_n[i]) r = ROW_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix lines plus the decoded key event outputs.
// The slave side is the scanner; the master side is the keypad/host.
interface keypad_scan_if;
  import keypad_scan_pkg::*;

  logic [NUM_ROWS-1:0]   row_n;
  logic [NUM_COLS-1:0]   col_n;
  logic [KEY_CODE_W-1:0] key_code;
  logic                  key_valid;
  logic                  key_held;

  modport master (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_held
  );

  modport slave (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_held
  );

endinterface

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchronizer for asynchronous level inputs, per-bit reset value.
module sync2 #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        meta_reg <= RESET_VAL[gi];
        sync_reg <= RESET_VAL[gi];
      end else begin
        meta_reg <= d[gi];
        sync_reg <= meta_reg;
      end
    end

    assign q[gi] = sync_reg;
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column scan, press debounce, release debounce.
// Column index doubles as the latched column while a key is being qualified.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int DWELL_CYC = 16,
  parameter int STABLE_N  = 12
) (
  input  logic         clk,
  input  logic         rst,
  keypad_scan_if.slave kp
);

  localparam int                  DW_W       = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [DW_W-1:0]     DWELL_LAST = DW_W'(DWELL_CYC - 1);

  logic [NUM_ROWS-1:0]   rows;

  scan_state_t           state_reg,     state_next;
  logic [IDX_W-1:0]      idx_reg,       idx_next;
  logic [ROW_W-1:0]      row_reg,       row_next;
  logic [DW_W-1:0]       dwell_reg,     dwell_next;
  logic [STABLE_N-1:0]   stable_reg,    stable_next;
  logic [STABLE_N-1:0]   stable_inc;
  logic [NUM_COLS-1:0]   col_n_reg,     col_n_next;
  logic [KEY_CODE_W-1:0] key_code_reg,  key_code_next;
  logic                  key_valid_reg, key_valid_next;
  logic                  key_held_reg,  key_held_next;
  logic                  row_low;

  sync2 #(
    .WIDTH     (NUM_ROWS),
    .RESET_VAL ({NUM_ROWS{1'b1}})
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (kp.row_n),
    .q   (rows)
  );

  assign row_low    = ~rows[row_reg];
  assign stable_inc = (&stable_reg) ? stable_reg : stable_reg + 1'b1;

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    row_next       = row_reg;
    dwell_next     = dwell_reg;
    stable_next    = stable_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;
    key_held_next  = key_held_reg;

    case (state_reg)
      SCAN: begin
        if (dwell_reg == DWELL_LAST) begin
          dwell_next = '0;
          if (&rows) begin
            idx_next = idx_reg + 1'b1;
          end else begin
            row_next    = lowest_low_row(rows);
            stable_next = '0;
            state_next  = DEBOUNCE;
          end
        end else begin
          dwell_next = dwell_reg + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (!row_low) begin
          idx_next    = idx_reg + 1'b1;
          stable_next = '0;
          state_next  = SCAN;
        end else if (stable_inc[STABLE_N-1]) begin
          // Accept on the clock the counter would reach its MSB.
          key_code_next  = {row_reg, idx_reg};
          key_valid_next = 1'b1;
          key_held_next  = 1'b1;
          stable_next    = '0;
          state_next     = HELD;
        end else begin
          stable_next = stable_inc;
        end
      end

      HELD: begin
        // Other rows are ignored here, so a second key cannot raise an event.
        if (row_low) begin
          stable_next = '0;
        end else if (stable_inc[STABLE_N-1]) begin
          key_held_next = 1'b0;
          idx_next      = idx_reg + 1'b1;
          stable_next   = '0;
          state_next    = SCAN;
        end else begin
          stable_next = stable_inc;
        end
      end

      default: begin
        state_next  = SCAN;
        idx_next    = '0;
        dwell_next  = '0;
        stable_next = '0;
      end
    endcase
  end

  for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
    assign col_n_next[gi] = (idx_next != IDX_W'(gi));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= SCAN;
      idx_reg       <= '0;
      row_reg       <= '0;
      dwell_reg     <= '0;
      stable_reg    <= '0;
      col_n_reg     <= '1;
      key_code_reg  <= '0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      row_reg       <= row_next;
      dwell_reg     <= dwell_next;
      stable_reg    <= stable_next;
      col_n_reg     <= col_n_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      key_held_reg  <= key_held_next;
    end
  end

  assign kp.col_n     = col_n_reg;
  assign kp.key_code  = key_code_reg;
  assign kp.key_valid = key_valid_reg;
  assign kp.key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: keypad matrix model plus timing/code expectations.
`timescale 1ns/1ps
module tb_keypad_scan;

  localparam int DWELL = 16;
  localparam int SN    = 4;
  localparam int HALF  = 1 << (SN - 1);
  localparam int SYNC  = 2;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_err;

  logic [3:0][3:0] pressed;
  logic            bounce_up;
  logic [3:0]      row_gen;

  int         pulse_cnt;
  int         last_pulse_cyc;
  logic [3:0] last_pulse_code;

  keypad_scan_if kif();

  keypad_scan #(.DWELL_CYC(DWELL), .STABLE_N(SN)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Keypad matrix: a pressed switch shorts its row to its column when that column is driven low.
  always_comb begin
    row_gen = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !kif.col_n[c] && !bounce_up) row_gen[r] = 1'b0;
  end
  assign kif.row_n = row_gen;

  function automatic logic [3:0] colmask(input logic [1:0] c);
    colmask = ~(4'b0001 << c);
  endfunction

  task automatic step();
    @(negedge clk);
    if (rst && kif.key_valid) begin
      pulse_cnt++;
      last_pulse_cyc  = cyc;
      last_pulse_code = kif.key_code;
    end
  endtask

  // Leaves col_n off the target, then returns the cycle at which the target column is entered.
  task automatic wait_col_entry(input logic [1:0] c, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < 8 * DWELL && kif.col_n === colmask(c); i++) step();
    for (int i = 0; i < 8 * DWELL; i++) begin
      step();
      if (kif.col_n === colmask(c)) begin
        at_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic wait_off_col(input logic [1:0] c);
    for (int i = 0; i < 8 * DWELL && kif.col_n === colmask(c); i++) step();
  endtask

  task automatic wait_pulse(input int p0, input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (pulse_cnt != p0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_held_low(input int bound, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (kif.key_held === 1'b0) begin
        at_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; pressed = '0; bounce_up = 1'b0;
    repeat (3) step();
    n_cmp++; if (kif.col_n !== 4'b1111) begin n_err++; $display("FAIL reset_col_n got=%b want=1111", kif.col_n); end
    n_cmp++; if (kif.key_code !== 4'h0) begin n_err++; $display("FAIL reset_key_code got=%h want=0", kif.key_code); end
    n_cmp++; if (kif.key_valid !== 1'b0) begin n_err++; $display("FAIL reset_key_valid got=%b want=0", kif.key_valid); end
    n_cmp++; if (kif.key_held !== 1'b0) begin n_err++; $display("FAIL reset_key_held got=%b want=0", kif.key_held); end
    rst = 1'b1;
    step();
    n_cmp++; if (kif.col_n !== 4'b1110) begin n_err++; $display("FAIL first_col got=%b want=1110", kif.col_n); end
  endtask

  task automatic test_idle_scan();
    logic [3:0] prev;
    logic [1:0] exp_idx;
    int         t_prev, n_tr, p0;
    prev = kif.col_n; exp_idx = 2'd0; t_prev = -1; n_tr = 0; p0 = pulse_cnt;
    for (int i = 0; i < 6 * DWELL + 10 && n_tr < 5; i++) begin
      step();
      if (kif.col_n !== prev) begin
        exp_idx = exp_idx + 2'd1;
        n_cmp++;
        if (kif.col_n !== colmask(exp_idx)) begin
          n_err++; $display("FAIL idle_seq got=%b want=%b", kif.col_n, colmask(exp_idx));
        end
        if (t_prev >= 0) begin
          n_cmp++;
          if (cyc - t_prev != DWELL) begin
            n_err++; $display("FAIL idle_dwell got=%0d want=%0d", cyc - t_prev, DWELL);
          end
        end
        t_prev = cyc; prev = kif.col_n; n_tr++;
      end
    end
    n_cmp++; if (n_tr != 5) begin n_err++; $display("FAIL idle_transitions got=%0d want=5", n_tr); end
    n_cmp++; if (pulse_cnt != p0) begin n_err++; $display("FAIL idle_valid got=%0d want=0", pulse_cnt - p0); end
  endtask

  task automatic test_press(input logic [1:0] r, input logic [1:0] c);
    int  x, p0, rel, fall, hold;
    bit  got;
    logic [3:0] exp_code;
    exp_code = {r, c};
    wait_off_col(c);
    pressed[r][c] = 1'b1;
    wait_col_entry(c, x);
    p0 = pulse_cnt;
    wait_pulse(p0, DWELL + HALF + 10, got);
    n_cmp++; if (!got || x < 0) begin n_err++; $display("FAIL press_timeout key=%h", exp_code); end
    n_cmp++; if (last_pulse_cyc - x != DWELL + HALF) begin
      n_err++; $display("FAIL press_latency got=%0d want=%0d", last_pulse_cyc - x, DWELL + HALF); end
    n_cmp++; if (last_pulse_code !== exp_code) begin
      n_err++; $display("FAIL press_code got=%h want=%h", last_pulse_code, exp_code); end
    n_cmp++; if (kif.key_held !== 1'b1) begin n_err++; $display("FAIL press_held got=%b want=1", kif.key_held); end
    step();
    n_cmp++; if (kif.key_valid !== 1'b0) begin n_err++; $display("FAIL valid_width got=%b want=0", kif.key_valid); end
    hold = $urandom_range(30, 0);
    repeat (hold) step();
    n_cmp++; if (kif.key_code !== exp_code || pulse_cnt != p0 + 1) begin
      n_err++; $display("FAIL hold_code got=%h/%0d want=%h/1", kif.key_code, pulse_cnt - p0, exp_code); end
    pressed[r][c] = 1'b0;
    rel = cyc;
    wait_held_low(SYNC + HALF + 10, fall);
    n_cmp++; if (fall - rel != SYNC + HALF) begin
      n_err++; $display("FAIL release_latency got=%0d want=%0d", fall - rel, SYNC + HALF); end
    n_cmp++; if (kif.col_n !== colmask(c + 2'd1)) begin
      n_err++; $display("FAIL release_next_col got=%b want=%b", kif.col_n, colmask(c + 2'd1)); end
    $display("press key=%h latency=%0d release=%0d", exp_code, last_pulse_cyc - x, fall - rel);
  endtask

  task automatic test_clean_press();
    test_press(2'd2, 2'd1);
    for (int k = 0; k < 3; k++) test_press(2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)));
  endtask

  task automatic test_bounce();
    logic [1:0] r, c;
    int  x, p0, fall;
    bit  got;
    r = 2'($urandom_range(3, 0)); c = 2'($urandom_range(3, 0));
    wait_off_col(c);
    pressed[r][c] = 1'b1;
    wait_col_entry(c, x);
    p0 = pulse_cnt;
    for (int k = 0; k < 40; k++) begin
      bounce_up = ((k / 3) % 2) == 1;
      step();
    end
    bounce_up = 1'b0;
    n_cmp++; if (pulse_cnt != p0) begin n_err++; $display("FAIL bounce_early got=%0d want=0", pulse_cnt - p0); end
    wait_pulse(p0, 8 * DWELL, got);
    repeat (20) step();
    n_cmp++; if (pulse_cnt != p0 + 1) begin n_err++; $display("FAIL bounce_count got=%0d want=1", pulse_cnt - p0); end
    n_cmp++; if (last_pulse_code !== {r, c}) begin
      n_err++; $display("FAIL bounce_code got=%h want=%h", last_pulse_code, {r, c}); end
    pressed[r][c] = 1'b0;
    wait_held_low(SYNC + HALF + 10, fall);
    n_cmp++; if (fall < 0) begin n_err++; $display("FAIL bounce_release got=timeout want=fall"); end
    $display("bounce key=%h pulses=%0d", {r, c}, pulse_cnt - p0);
  endtask

  task automatic test_two_keys(input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] c);
    logic [1:0] r1, r2;
    int  p0, rel, fall;
    bit  got;
    r1 = (ra < rb) ? ra : rb;
    r2 = (ra < rb) ? rb : ra;
    wait_off_col(c);
    pressed[r1][c] = 1'b1; pressed[r2][c] = 1'b1;
    p0 = pulse_cnt;
    wait_pulse(p0, 8 * DWELL, got);
    n_cmp++; if (!got || last_pulse_code !== {r1, c}) begin
      n_err++; $display("FAIL two_first_code got=%h want=%h", last_pulse_code, {r1, c}); end
    repeat (40) step();
    n_cmp++; if (pulse_cnt != p0 + 1) begin n_err++; $display("FAIL two_no_event got=%0d want=1", pulse_cnt - p0); end
    pressed[r1][c] = 1'b0;
    rel = cyc;
    wait_held_low(SYNC + HALF + 10, fall);
    n_cmp++; if (fall - rel != SYNC + HALF) begin
      n_err++; $display("FAIL two_release got=%0d want=%0d", fall - rel, SYNC + HALF); end
    wait_pulse(p0 + 1, 8 * DWELL, got);
    n_cmp++; if (!got || last_pulse_code !== {r2, c}) begin
      n_err++; $display("FAIL two_second_code got=%h want=%h", last_pulse_code, {r2, c}); end
    pressed[r2][c] = 1'b0;
    wait_held_low(SYNC + HALF + 10, fall);
    $display("two_keys col=%0d rows=%0d,%0d pulses=%0d", c, r1, r2, pulse_cnt - p0);
  endtask

  task automatic test_reset_mid_debounce();
    logic [1:0] r, c;
    int x, k, p0;
    r = 2'($urandom_range(3, 0)); c = 2'($urandom_range(3, 0));
    k = $urandom_range(HALF - 2, 1);
    wait_off_col(c);
    pressed[r][c] = 1'b1;
    wait_col_entry(c, x);
    repeat (DWELL + k) step();
    p0 = pulse_cnt;
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (kif.col_n !== 4'b1111 || kif.key_code !== 4'h0 || kif.key_valid !== 1'b0 || kif.key_held !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_outputs got=%b/%h/%b/%b want=1111/0/0/0",
                        kif.col_n, kif.key_code, kif.key_valid, kif.key_held); end
    repeat (HALF + 2) step();
    n_cmp++; if (pulse_cnt != p0 || kif.key_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_valid got=%0d want=0", pulse_cnt - p0); end
    pressed = '0;
    rst = 1'b1;
    step();
    n_cmp++; if (kif.col_n !== 4'b1110) begin n_err++; $display("FAIL mid_reset_restart got=%b want=1110", kif.col_n); end
    repeat (DWELL + HALF + 4) step();
    n_cmp++; if (pulse_cnt != p0) begin n_err++; $display("FAIL mid_reset_late got=%0d want=0", pulse_cnt - p0); end
    $display("reset_mid_debounce key=%h offset=%0d", {r, c}, k);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; pulse_cnt = 0; last_pulse_cyc = 0; last_pulse_code = '0;
    rst = 1'b0; pressed = '0; bounce_up = 1'b0;
    test_reset();
    test_idle_scan();
    test_clean_press();
    test_bounce();
    test_two_keys(2'd1, 2'd3, 2'd0);
    test_two_keys(2'd0, 2'd2, 2'($urandom_range(3, 0)));
    test_reset_mid_debounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
